// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline: load-use interlock,
// branch flush, data-memory wait with timeout, and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int REG_COUNT   = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs2_addr,
  input  logic                         id_uses_rs1,
  input  logic                         id_uses_rs2,
  input  logic                         ex_mem_read,
  input  logic [$clog2(REG_COUNT)-1:0] ex_rd_addr,
  input  logic                         ex_branch_taken,
  input  logic                         mem_req,
  input  logic                         dmem_ready,
  output logic                         pc_en,
  output logic                         if_id_en,
  output logic                         id_ex_en,
  output logic                         ex_mem_en,
  output logic                         if_id_flush,
  output logic                         id_ex_flush,
  output logic                         mem_wb_bubble,
  output logic                         mem_err,
  output logic [CNT_WIDTH-1:0]         stall_cnt,
  output logic [CNT_WIDTH-1:0]         flush_cnt
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;
  logic in_error;
  logic branch_rule;

  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rd_addr != '0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
  assign in_error  = (state_q == ERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A returning dmem_ready always beats an expiring timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR:   state_d = ERROR;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    branch_rule   = 1'b0;
    if (in_error || mem_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_rule = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_rule && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign mem_err   = in_error;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_COUNT, default 32: number of architectural registers; address width is clog2(REG_COUNT).
REQ-002 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-003 Parameter MEM_TIMEOUT, default 16: maximum consecutive data-memory wait cycles before error; legal range 2..255.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 id_rs1_addr, id_rs2_addr  input  clog2(REG_COUNT) each  source registers of the instruction in ID.
REQ-007 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads the corresponding source.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_rd_addr  input  clog2(REG_COUNT)  destination register of the EX instruction.
REQ-010 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-011 mem_req  input  1  MEM-stage instruction accesses data memory.
REQ-012 dmem_ready  input  1  data memory completes the access this cycle.
REQ-013 pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  capture enables for PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-014 if_id_flush, id_ex_flush  output  1 each  load zeros (bubble) into IF/ID, ID/EX.
REQ-015 mem_wb_bubble  output  1  load a bubble into MEM/WB.
REQ-016 mem_err  output  1  sticky data-memory timeout flag.
REQ-017 stall_cnt, flush_cnt  output  CNT_WIDTH each  saturating performance counters.

Function
REQ-018 FSM states: RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-019 mem_stall = mem_req & ~dmem_ready; load_use = ex_mem_read & (ex_rd_addr != 0) & ((id_uses_rs1 & id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & id_rs2_addr == ex_rd_addr)).
REQ-020 Control outputs are combinational from state and inputs; priority ERROR > mem_stall > ex_branch_taken > load_use > normal.
REQ-021 Normal: all four enables 1, both flushes 0, mem_wb_bubble 0.
REQ-022 mem_stall (RUN or MEM_WAIT): all enables 0, flushes 0, mem_wb_bubble 1; a pending branch or load-use waits, because the EX inputs are held.
REQ-023 ex_branch_taken: all enables 1, if_id_flush 1, id_ex_flush 1, mem_wb_bubble 0.
REQ-024 load_use: pc_en 0, if_id_en 0, id_ex_en 1, id_ex_flush 1, ex_mem_en 1, mem_wb_bubble 0.
REQ-025 RUN -> MEM_WAIT on mem_stall; wait_cnt is set to 1 on this transition.
REQ-026 MEM_WAIT: if ~mem_stall -> RUN; otherwise wait_cnt increments.
REQ-027 MEM_WAIT -> ERROR on the edge that ends the MEM_TIMEOUT-th consecutive stalled cycle, when wait_cnt == MEM_TIMEOUT-1 and mem_stall is still 1.
REQ-028 ERROR: all enables 0, flushes 0, mem_wb_bubble 1, mem_err 1; the block stays in ERROR until reset, whatever the inputs.
REQ-029 dmem_ready arriving in the same cycle as timeout expiry: ready wins, and the next state is RUN.
REQ-030 stall_cnt increments on each clock with pc_en == 0, including ERROR cycles, and saturates at all-ones.
REQ-031 flush_cnt increments on each clock where the branch rule (REQ-023) applies, and saturates at all-ones.
REQ-032 load_use on x0 (ex_rd_addr == 0) never stalls.

Reset
REQ-033 While rst = 0: state RUN, wait_cnt 0, mem_err 0, stall_cnt 0, flush_cnt 0; control outputs follow RUN rules from the current inputs.
REQ-034 Reset asserted in MEM_WAIT or ERROR returns the block to RUN immediately and asynchronously; the first edge after release evaluates from RUN.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cnt increments by 1.
REQ-036 Branch: ex_branch_taken=1 together with a load-use hit -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt increments by 1, stall_cnt unchanged.
REQ-037 Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 and mem_wb_bubble=1 for 3 cycles; normal on cycle 4; state back in RUN.
REQ-038 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 stalled cycles, mem_err=1 sticky, enables 0; rst pulse returns to RUN with counters cleared.
REQ-039 Boundary: dmem_ready=1 exactly in the 4th stalled cycle (MEM_TIMEOUT=4) -> no error, RUN next cycle.
REQ-040 Saturation: CNT_WIDTH=4, 20 load-use stall cycles -> stall_cnt holds at 15.
